parallel_adder: RTL and testbench



---
 rtl/parallel_adder.sv | 52 +++++
 tb/tb_parallel_adder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/parallel_adder.sv
// 3-bit ripple-carry adder whose sum and carry-out are captured into holding
// registers once per MAX_COUNT clocks, paced by a free-running interval counter.
module parallel_adder #(
    parameter int MAX_COUNT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] A,
    input  logic [2:0] B,
    input  logic       Cin,
    output logic [2:0] Sum,
    output logic       Cout
);

    localparam int CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

    logic [CW-1:0] cnt;
    logic          upd;
    logic [3:0]    c;
    logic [2:0]    s;

    // Three chained full adders; c[0] is the external carry-in.
    always_comb begin
        c    = 4'b0000;
        s    = 3'b000;
        c[0] = Cin;
        for (int i = 0; i < 3; i++) begin
            s[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
    end

    assign upd = (cnt == CW'(MAX_COUNT - 1));

    // Reset has priority over a coincident strobe, so a reset edge never loads a sum.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            Sum  <= 3'b000;
            Cout <= 1'b0;
        end else begin
            if (upd) begin
                cnt  <= '0;
                Sum  <= s;
                Cout <= c[3];
            end else begin
                cnt  <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_parallel_adder.sv
// Directed bench for parallel_adder with three instances: MAX_COUNT=1, 4 and the default 1000.
module tb_parallel_adder;

    logic       clk = 1'b0;
    logic       rst1, rst4, rstk;
    logic [2:0] A, B;
    logic       Cin;
    logic [2:0] sum1, sum4, sumk;
    logic       cout1, cout4, coutk;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    parallel_adder #(.MAX_COUNT(1)) dut1 (
        .clk(clk), .rst(rst1), .A(A), .B(B), .Cin(Cin), .Sum(sum1), .Cout(cout1)
    );

    parallel_adder #(.MAX_COUNT(4)) dut4 (
        .clk(clk), .rst(rst4), .A(A), .B(B), .Cin(Cin), .Sum(sum4), .Cout(cout4)
    );

    parallel_adder dutk (
        .clk(clk), .rst(rstk), .A(A), .B(B), .Cin(Cin), .Sum(sumk), .Cout(coutk)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b, input logic ci);
        A   = a;
        B   = b;
        Cin = ci;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        rst1 = 1'b0;
        rst4 = 1'b0;
        rstk = 1'b0;
        applyStimulus(3'd7, 3'd7, 1'b1);

        // Reset with nonzero inputs (MAX_COUNT=4 and MAX_COUNT=1, where every edge strobes)
        tick();
        checkOutput("reset4_e1", {cout4, sum4}, 4'd0);
        checkOutput("reset1_e1", {cout1, sum1}, 4'd0);
        tick();
        checkOutput("reset4_e2", {cout4, sum4}, 4'd0);
        checkOutput("reset1_e2", {cout1, sum1}, 4'd0);

        // Basic add and extremes, MAX_COUNT=1
        rst1 = 1'b1;
        applyStimulus(3'd3, 3'd2, 1'b0);
        tick();
        checkOutput("basic_3p2", {cout1, sum1}, 4'd5);
        applyStimulus(3'd5, 3'd4, 1'b1);
        tick();
        checkOutput("basic_5p4p1", {cout1, sum1}, 4'd10);
        applyStimulus(3'd7, 3'd7, 1'b1);
        tick();
        checkOutput("max_7p7p1", {cout1, sum1}, 4'd15);
        applyStimulus(3'd0, 3'd0, 1'b1);
        tick();
        checkOutput("min_cin", {cout1, sum1}, 4'd1);

        // Hold interval, MAX_COUNT=4
        rst4 = 1'b1;
        applyStimulus(3'd1, 3'd1, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            tick();
            checkOutput($sformatf("hold_e%0d", e), {cout4, sum4}, 4'd0);
        end
        tick();
        checkOutput("hold_e4", {cout4, sum4}, 4'd2);
        tick();
        checkOutput("hold_e5", {cout4, sum4}, 4'd2);
        applyStimulus(3'd6, 3'd3, 1'b0);
        for (int e = 6; e <= 7; e++) begin
            tick();
            checkOutput($sformatf("hold_e%0d", e), {cout4, sum4}, 4'd2);
        end
        tick();
        checkOutput("hold_e8", {cout4, sum4}, 4'd9);

        // Reset mid-interval: edge 1 of the new interval, then reset on edge 2
        tick();
        rst4 = 1'b0;
        tick();
        checkOutput("midrst", {cout4, sum4}, 4'd0);
        rst4 = 1'b1;
        applyStimulus(3'd2, 3'd3, 1'b1);
        for (int e = 1; e <= 3; e++) begin
            tick();
            checkOutput($sformatf("midrst_e%0d", e), {cout4, sum4}, 4'd0);
        end
        tick();
        checkOutput("midrst_e4", {cout4, sum4}, 4'd6);

        // Reset coinciding with a strobe edge wins over the load
        applyStimulus(3'd4, 3'd1, 1'b0);
        for (int e = 1; e <= 3; e++) tick();
        rst4 = 1'b0;
        tick();
        checkOutput("rst_on_strobe", {cout4, sum4}, 4'd0);
        rst4 = 1'b1;

        // Exhaustive sweep, MAX_COUNT=1
        for (int i = 0; i < 128; i++) begin
            logic [6:0] v;
            logic [3:0] exp;
            v = 7'(i);
            applyStimulus(v[6:4], v[3:1], v[0]);
            exp = 4'(v[6:4]) + 4'(v[3:1]) + 4'(v[0]);
            tick();
            checkOutput($sformatf("exh_%0d", i), {cout1, sum1}, exp);
        end

        // Default MAX_COUNT=1000: first load on edge 1000 after release
        tick();
        rstk = 1'b1;
        applyStimulus(3'd4, 3'd5, 1'b0);
        tick();
        checkOutput("k_e1", {coutk, sumk}, 4'd0);
        for (int e = 2; e <= 999; e++) tick();
        checkOutput("k_e999", {coutk, sumk}, 4'd0);
        tick();
        checkOutput("k_e1000", {coutk, sumk}, 4'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
